// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//   Frame handshake and result bus of the bit-serial subtractor.
//   master : drives start/bit_valid/a_bit/b_bit, observes everything else
//   slave  : the subtractor itself
//   Signals:
//     start      single-cycle frame request
//     bit_valid  a_bit/b_bit carry an operand bit this cycle
//     a_bit      minuend bit, LSB first
//     b_bit      subtrahend bit, LSB first
//     busy       frame in progress
//     diff_valid diff_bit valid this cycle
//     diff_bit   registered difference bit
//     done       one-cycle frame-complete pulse
//     result     assembled WIDTH-bit difference
//     borrow     final borrow out (A < B unsigned)
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             diff_valid;
    logic             diff_bit;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, diff_valid, diff_bit, done, result, borrow
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, diff_valid, diff_bit, done, result, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial, LSB-first subtractor computing (A - B) mod 2^WIDTH.
//   Each accepted operand bit yields a registered difference bit one cycle
//   later; after WIDTH bits the parallel result and final borrow are
//   presented together with a one-cycle done pulse.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if.slave (handshake, operand bits, results)
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    // One extra bit so the counter can hold WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow_q;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_diff_valid;
    logic             r_diff_bit;
    logic             r_done;
    logic             r_borrow;

    // Full-subtractor cell on the current operand bits.
    logic w_d;
    logic w_borrow_next;
    logic w_last_bit;

    assign w_d           = bus.a_bit ^ bus.b_bit ^ r_borrow_q;
    assign w_borrow_next = (~bus.a_bit & bus.b_bit)
                         | (~(bus.a_bit ^ bus.b_bit) & r_borrow_q);
    assign w_last_bit    = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_borrow_q   <= 1'b0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_diff_valid <= 1'b0;
            r_diff_bit   <= 1'b0;
            r_done       <= 1'b0;
            r_borrow     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; the branches below
            // only raise them, so no path can leave a stale pulse behind.
            r_diff_valid <= 1'b0;
            r_done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_borrow_q <= 1'b0;
                        r_result   <= '0;
                        r_borrow   <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (bus.bit_valid) begin
                        r_diff_bit   <= w_d;
                        r_diff_valid <= 1'b1;
                        r_borrow_q   <= w_borrow_next;
                        // Right shift: the first bit reaches bit 0 after WIDTH bits.
                        r_result     <= {w_d, r_result[WIDTH-1:1]};
                        r_cnt        <= r_cnt + 1'b1;
                        if (w_last_bit) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_borrow <= w_borrow_next;
                        end
                    end
                end

                S_DONE: begin
                    if (bus.start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_borrow_q <= 1'b0;
                        r_result   <= '0;
                        r_borrow   <= 1'b0;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.diff_valid = r_diff_valid;
    assign bus.diff_bit   = r_diff_bit;
    assign bus.done       = r_done;
    assign bus.result     = r_result;
    assign bus.borrow     = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH = 8). Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame and streams a/b LSB first. stall_a/stall_b: bit index
    // after which bit_valid drops for two cycles (-1 = none). restart_bit:
    // bit index during which start is pulsed again (-1 = none). Returns in
    // the DONE cycle so a following call can issue a back-to-back start.
    task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_res, input logic exp_bor,
                             input int stall_a, input int stall_b, input int restart_bit);
        sif.start = 1'b1;
        sif.bit_valid = 1'b0;
        step();
        sif.start = 1'b0;
        check1({name, " busy after start"}, sif.busy, 1'b1);
        check1({name, " borrow cleared on start"}, sif.borrow, 1'b0);
        check8({name, " result cleared on start"}, sif.result, 8'h00);
        for (int i = 0; i < WIDTH; i++) begin
            sif.a_bit = a[i];
            sif.b_bit = b[i];
            sif.bit_valid = 1'b1;
            sif.start = (i == restart_bit);
            step();
            sif.start = 1'b0;
            sif.bit_valid = 1'b0;
            check1($sformatf("%s diff_valid bit %0d", name, i), sif.diff_valid, 1'b1);
            check1($sformatf("%s diff_bit %0d", name, i), sif.diff_bit, exp_res[i]);
            check1($sformatf("%s done at bit %0d", name, i), sif.done, (i == WIDTH - 1));
            if (i == stall_a || i == stall_b) begin
                for (int s = 0; s < 2; s++) begin
                    sif.a_bit = 1'b1;
                    sif.b_bit = 1'b0;
                    step();
                    check1($sformatf("%s stall diff_valid b%0d s%0d", name, i, s), sif.diff_valid, 1'b0);
                    check1($sformatf("%s stall done b%0d s%0d", name, i, s), sif.done, 1'b0);
                    check1($sformatf("%s stall busy b%0d s%0d", name, i, s), sif.busy, 1'b1);
                end
            end
        end
        check8({name, " result"}, sif.result, exp_res);
        check1({name, " borrow"}, sif.borrow, exp_bor);
        check1({name, " busy in DONE"}, sif.busy, 1'b0);
    endtask

    // One cycle in IDLE with garbage on the bit inputs: must be ignored.
    task automatic idle_step(input string name, input logic [7:0] exp_res, input logic exp_bor);
        sif.bit_valid = 1'b1;
        sif.a_bit = 1'b0;
        sif.b_bit = 1'b1;
        step();
        sif.bit_valid = 1'b0;
        check1({name, " idle done"}, sif.done, 1'b0);
        check1({name, " idle busy"}, sif.busy, 1'b0);
        check1({name, " idle diff_valid"}, sif.diff_valid, 1'b0);
        check8({name, " idle result hold"}, sif.result, exp_res);
        check1({name, " idle borrow hold"}, sif.borrow, exp_bor);
    endtask

    task automatic check_reset_outputs(input string name);
        check1({name, " busy"}, sif.busy, 1'b0);
        check1({name, " diff_valid"}, sif.diff_valid, 1'b0);
        check1({name, " diff_bit"}, sif.diff_bit, 1'b0);
        check1({name, " done"}, sif.done, 1'b0);
        check8({name, " result"}, sif.result, 8'h00);
        check1({name, " borrow"}, sif.borrow, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        sif.start = 1'b0;
        sif.bit_valid = 1'b0;
        sif.a_bit = 1'b0;
        sif.b_bit = 1'b0;

        // Reset state.
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_step("post-reset", 8'h00, 1'b0);

        // 5 - 3 = 2.
        run_frame("f1", 8'h05, 8'h03, 8'h02, 1'b0, -1, -1, -1);
        idle_step("f1", 8'h02, 1'b0);

        // 3 - 5 = 0xFE with borrow.
        run_frame("f2", 8'h03, 8'h05, 8'hFE, 1'b1, -1, -1, -1);
        idle_step("f2", 8'hFE, 1'b1);

        // 0xFF - 0x01 with two-cycle stalls after bits 2 and 5.
        run_frame("f3", 8'hFF, 8'h01, 8'hFE, 1'b0, 2, 5, -1);
        idle_step("f3", 8'hFE, 1'b0);

        // 0x80 - 0x80 with start pulsed again at bit 4.
        run_frame("f4", 8'h80, 8'h80, 8'h00, 1'b0, -1, -1, 4);
        idle_step("f4", 8'h00, 1'b0);

        // Mid-frame reset after bit 3 (A=0x10, B=0x20 aborted).
        sif.start = 1'b1;
        step();
        sif.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.a_bit = (i == 4);
            sif.b_bit = 1'b0;
            sif.bit_valid = 1'b1;
            step();
        end
        sif.bit_valid = 1'b0;
        check1("abort busy before reset", sif.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        step();
        check_reset_outputs("held reset");
        rst_n = 1'b1;
        step();
        check1("after reset done", sif.done, 1'b0);
        check1("after reset busy", sif.busy, 1'b0);

        // Fresh frame after reset: 0x10 - 0x20 = 0xF0 with borrow.
        run_frame("f5", 8'h10, 8'h20, 8'hF0, 1'b1, -1, -1, -1);
        idle_step("f5", 8'hF0, 1'b1);

        // Back-to-back: second start issued in the DONE cycle of the first.
        run_frame("f6a", 8'h0A, 8'h0A, 8'h00, 1'b0, -1, -1, -1);
        run_frame("f6b", 8'h01, 8'h02, 8'hFF, 1'b1, -1, -1, -1);
        idle_step("f6b", 8'hFF, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes A - B over WIDTH-bit operands streamed one bit per accepted cycle.
- Emits each difference bit serially with one cycle of latency, plus the assembled parallel result and the final borrow.
- Serves as the sequential counterpart to the combinational adder cells in the arithmetic block set. Used where operands arrive on serial links.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a new subtraction frame
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
- a_bit  input  1  minuend bit, LSB first
- b_bit  input  1  subtrahend bit, LSB first
- busy  output  1  high while a frame is in progress (RUN state)
- diff_valid  output  1  diff_bit valid this cycle
- diff_bit  output  1  registered difference bit
- done  output  1  one-cycle pulse: frame complete, result/borrow valid
- result  output  WIDTH  assembled difference, LSB = first bit
- borrow  output  1  final borrow out (1 means A < B unsigned)

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0: state=IDLE; busy, diff_valid, diff_bit, done, borrow = 0; result = 0; internal borrow_q = 0; bit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN; clear borrow_q, counter and result.
  - bit_valid is ignored in IDLE.
- RUN:
  - busy=1.
  - Each cycle with bit_valid=1:
    - d = a_bit ^ b_bit ^ borrow_q
    - borrow_q <= (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q)
    - diff_bit <= d; diff_valid <= 1 on the next cycle. Latency is exactly 1 cycle.
    - result <= {d, result[WIDTH-1:1]}, a right shift so the LSB lands at bit 0 after WIDTH bits.
    - counter increments.
  - bit_valid=0: stall. Counter, borrow_q and result hold; diff_valid=0 next cycle.
  - start asserted during RUN is ignored.
  - When the WIDTH-th bit is accepted (counter == WIDTH-1 and bit_valid=1) -> DONE.
- DONE (one cycle):
  - done=1; borrow = final borrow_q; result holds the final value.
  - diff_valid=1 for the last bit, coincident with done.
  - Next state is IDLE, or RUN if start=1 in DONE (back-to-back frames). A back-to-back start clears borrow_q, counter and result on entry to RUN.
  - bit_valid in DONE is ignored.
- result and borrow hold their last values in IDLE until the next start clears them. borrow is cleared on start.
- Arithmetic is modulo 2^WIDTH: result = (A - B) mod 2^WIDTH, borrow = (A < B).
- Counter width is clog2(WIDTH)+1. No wrap occurs inside a frame.
- Reset mid-frame aborts immediately: no done pulse, and all outputs return to reset values.

Test Plan:
- WIDTH=8, start, then stream A=0x05, B=0x03 with bit_valid held high -> 8 diff_valid pulses with bits 0,1,0,0,0,0,0,0; done on cycle 9 after start; result=0x02; borrow=0.
- A=0x03, B=0x05 -> result=0xFE, borrow=1; diff bits LSB-first 0,1,1,1,1,1,1,1.
- A=0xFF, B=0x01 with bit_valid deasserted for 2 cycles after bits 2 and 5 -> no diff_valid during stalls; done 12 cycles after start; result=0xFE; borrow=0.
- start pulsed again mid-frame at bit 4, A=0x80, B=0x80 -> ignored; single done; result=0x00; borrow=0.
- rst_n low for 1 cycle after bit 3, then a fresh frame A=0x10, B=0x20 -> outputs zero during reset with no done pulse; new frame gives result=0xF0, borrow=1.
- start asserted in the DONE cycle of frame A=0x0A, B=0x0A -> first frame gives result=0x00, borrow=0; second frame A=0x01, B=0x02 starts immediately and gives result=0xFF, borrow=1.
